// File: rtl/hc194_seq.sv
// Command sequencer that drives a 4-bit universal shift register (hc194) through LOAD/SHR/SHL/ROTR commands.
// Optional abort support is compiled in with `define HC194_SEQ_ABORT_EN.
module hc194_seq #(
    parameter int CNT_W = 4
) (
    input  logic             CP,
    input  logic             MRN,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [CNT_W-1:0] CMD_CNT,
    input  logic [3:0]       CMD_DATA,
    input  logic             CMD_FILL,
    input  logic [3:0]       Q_IN,
    output logic             S0,
    output logic             S1,
    output logic [3:0]       D_OUT,
    output logic             DSR,
    output logic             DSL,
`ifdef HC194_SEQ_ABORT_EN
    input  logic             ABORT,
    output logic             ABORTED,
`endif
    output logic             DONE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    state_t           state, state_next;
    logic [1:0]       mode, mode_next;
    logic [3:0]       d_reg, d_next;
    logic             fill, fill_next;
    logic [CNT_W-1:0] count, count_next;
    logic             rotr, rotr_next;
`ifdef HC194_SEQ_ABORT_EN
    logic             aborted, aborted_next;
`endif

    // Only Q0 is needed, as the rotate feedback into DSR.
    logic unused_q;
    assign unused_q = ^Q_IN[3:1];

    always_ff @(posedge CP or negedge MRN) begin
        if (!MRN) begin
            state <= IDLE;
            mode  <= MODE_HOLD;
            d_reg <= 4'b0000;
            fill  <= 1'b0;
            count <= '0;
            rotr  <= 1'b0;
`ifdef HC194_SEQ_ABORT_EN
            aborted <= 1'b0;
`endif
        end else begin
            state <= state_next;
            mode  <= mode_next;
            d_reg <= d_next;
            fill  <= fill_next;
            count <= count_next;
            rotr  <= rotr_next;
`ifdef HC194_SEQ_ABORT_EN
            aborted <= aborted_next;
`endif
        end
    end

    // The mode lines are registered so the register acts on the edge after the sequencer decides.
    always_comb begin
        state_next = state;
        mode_next  = mode;
        d_next     = d_reg;
        fill_next  = fill;
        count_next = count;
        rotr_next  = rotr;
`ifdef HC194_SEQ_ABORT_EN
        aborted_next = aborted;
`endif
        case (state)
            IDLE: begin
                mode_next = MODE_HOLD;
                if (CMD_VALID) begin
                    fill_next = CMD_FILL;
                    rotr_next = (CMD_OP == OP_ROTR);
`ifdef HC194_SEQ_ABORT_EN
                    aborted_next = 1'b0;
`endif
                    if (CMD_OP == OP_LOAD) begin
                        mode_next  = MODE_LOAD;
                        d_next     = CMD_DATA;
                        count_next = CNT_W'(1);
                        state_next = RUN;
                    end else begin
                        count_next = CMD_CNT;
                        if (CMD_CNT == '0) begin
                            state_next = FIN;
                        end else begin
                            mode_next  = (CMD_OP == OP_SHL) ? MODE_SHL : MODE_SHR;
                            state_next = RUN;
                        end
                    end
                end
            end
            RUN: begin
`ifdef HC194_SEQ_ABORT_EN
                if (ABORT) begin
                    mode_next    = MODE_HOLD;
                    count_next   = '0;
                    aborted_next = 1'b1;
                    state_next   = FIN;
                end else
`endif
                if (count == CNT_W'(1)) begin
                    mode_next  = MODE_HOLD;
                    count_next = '0;
                    state_next = FIN;
                end else begin
                    count_next = count - CNT_W'(1);
                end
            end
            FIN: begin
                mode_next  = MODE_HOLD;
                rotr_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                mode_next  = MODE_HOLD;
                state_next = IDLE;
            end
        endcase
    end

    assign {S1, S0}  = mode;
    assign D_OUT     = d_reg;
    assign DSL       = fill;
    assign DSR       = (rotr && state == RUN) ? Q_IN[0] : fill;
    assign CMD_READY = (state == IDLE);
    assign DONE      = (state == FIN);
`ifdef HC194_SEQ_ABORT_EN
    assign ABORTED   = (state == FIN) && aborted;
`endif

endmodule

// File: tb/tb_hc194_seq.sv
// Directed bench for hc194_seq driving a behavioural hc194 register; checks mode lines, DONE timing and register contents.
// The abort section is compiled only when HC194_SEQ_ABORT_EN is defined.
module tb_hc194_seq;

    logic       cp;
    logic       mrn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_cnt;
    logic [3:0] cmd_data;
    logic       cmd_fill;
    logic [3:0] q;
    logic       s0, s1;
    logic [3:0] d_out;
    logic       dsr, dsl;
    logic       done;
`ifdef HC194_SEQ_ABORT_EN
    logic       abort;
    logic       aborted;
`endif

    int checks   = 0;
    int failures = 0;

    hc194_seq #(.CNT_W(4)) dut (
        .CP        (cp),
        .MRN       (mrn),
        .CMD_VALID (cmd_valid),
        .CMD_READY (cmd_ready),
        .CMD_OP    (cmd_op),
        .CMD_CNT   (cmd_cnt),
        .CMD_DATA  (cmd_data),
        .CMD_FILL  (cmd_fill),
        .Q_IN      (q),
        .S0        (s0),
        .S1        (s1),
        .D_OUT     (d_out),
        .DSR       (dsr),
        .DSL       (dsl),
`ifdef HC194_SEQ_ABORT_EN
        .ABORT     (abort),
        .ABORTED   (aborted),
`endif
        .DONE      (done)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    // Behavioural hc194 sharing CP and MRN with the sequencer.
    always @(posedge cp or negedge mrn) begin
        if (!mrn)
            q <= 4'b0000;
        else
            case ({s1, s0})
                2'b01:   q <= {dsr, q[3:1]};
                2'b10:   q <= {q[2:0], dsl};
                2'b11:   q <= d_out;
                default: q <= q;
            endcase
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", tag, observed, expected);
        end
    endtask

    // Presents a command at a falling edge and returns on the falling edge after the accept edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] cnt, input logic [3:0] data, input logic fill);
        int waited = 0;
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_data  = data;
        cmd_fill  = fill;
        cmd_valid = 1'b1;
        while (!cmd_ready && waited < 20) begin
            @(negedge cp);
            waited++;
        end
        checkOutput("accept_ready", {7'b0, cmd_ready}, 8'd1);
        @(posedge cp);
        @(negedge cp);
        cmd_valid = 1'b0;
    endtask

    task automatic stepCycle();
        @(negedge cp);
    endtask

    initial begin
        mrn       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_cnt   = 4'd0;
        cmd_data  = 4'd0;
        cmd_fill  = 1'b0;
`ifdef HC194_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (2) @(negedge cp);
        mrn = 1'b1;
        @(negedge cp);

        checkOutput("rst_ready", {7'b0, cmd_ready}, 8'd1);
        checkOutput("rst_mode",  {6'b0, s1, s0}, 8'd0);
        checkOutput("rst_done",  {7'b0, done}, 8'd0);
        checkOutput("rst_dout",  {4'b0, d_out}, 8'd0);
        checkOutput("rst_serial", {6'b0, dsr, dsl}, 8'd0);

        // LOAD 1011
        applyStimulus(2'b00, 4'd0, 4'b1011, 1'b0);
        checkOutput("load_mode", {6'b0, s1, s0}, 8'b11);
        checkOutput("load_dout", {4'b0, d_out}, 8'b1011);
        checkOutput("load_busy", {6'b0, cmd_ready, done}, 8'b00);
        stepCycle();
        checkOutput("load_q",    {4'b0, q}, 8'b1011);
        checkOutput("load_fin",  {5'b0, done, s1, s0}, 8'b100);
        stepCycle();
        checkOutput("load_idle", {6'b0, cmd_ready, done}, 8'b10);

        // SHR 2, fill 0: 1011 -> 0101 -> 0010
        applyStimulus(2'b01, 4'd2, 4'b0000, 1'b0);
        checkOutput("shr_mode0", {6'b0, s1, s0}, 8'b01);
        checkOutput("shr_ready", {7'b0, cmd_ready}, 8'd0);
        stepCycle();
        checkOutput("shr_q1",    {4'b0, q}, 8'b0101);
        checkOutput("shr_mode1", {5'b0, done, s1, s0}, 8'b001);
        stepCycle();
        checkOutput("shr_q2",    {4'b0, q}, 8'b0010);
        checkOutput("shr_fin",   {5'b0, done, s1, s0}, 8'b100);
        checkOutput("shr_dout_kept", {4'b0, d_out}, 8'b1011);
        stepCycle();

        // LOAD 0001, then SHL 3, fill 1: 0011, 0111, 1111
        applyStimulus(2'b00, 4'd0, 4'b0001, 1'b0);
        repeat (2) stepCycle();
        applyStimulus(2'b10, 4'd3, 4'b0000, 1'b1);
        checkOutput("shl_mode", {5'b0, dsl, s1, s0}, 8'b110);
        stepCycle();
        checkOutput("shl_q1", {4'b0, q}, 8'b0011);
        stepCycle();
        checkOutput("shl_q2", {3'b0, dsl, q}, 8'b10111);
        stepCycle();
        checkOutput("shl_q3", {3'b0, done, q}, 8'b11111);
        checkOutput("shl_dsl_fin", {7'b0, dsl}, 8'd1);
        stepCycle();

        // LOAD 1001, then ROTR 4: 1100, 0110, 0011, 1001
        applyStimulus(2'b00, 4'd0, 4'b1001, 1'b0);
        repeat (2) stepCycle();
        applyStimulus(2'b11, 4'd4, 4'b0000, 1'b0);
        checkOutput("rotr_mode", {6'b0, s1, s0}, 8'b01);
        checkOutput("rotr_dsr0", {7'b0, dsr}, 8'd1);
        stepCycle();
        checkOutput("rotr_q1", {4'b0, q}, 8'b1100);
        stepCycle();
        checkOutput("rotr_q2", {4'b0, q}, 8'b0110);
        stepCycle();
        checkOutput("rotr_q3", {3'b0, done, q}, 8'b00011);
        stepCycle();
        checkOutput("rotr_q4", {3'b0, done, q}, 8'b11001);
        stepCycle();

        // SHR 0: straight to DONE, register untouched
        applyStimulus(2'b01, 4'd0, 4'b0000, 1'b1);
        checkOutput("shr0_fin", {5'b0, done, s1, s0}, 8'b100);
        checkOutput("shr0_q",   {4'b0, q}, 8'b1001);
        stepCycle();
        checkOutput("shr0_idle", {3'b0, cmd_ready, q}, 8'b11001);

        // MRN during SHL 10 (fill 0): 1001 -> 0010 -> 0100, then reset
        applyStimulus(2'b10, 4'd10, 4'b0000, 1'b0);
        repeat (2) stepCycle();
        checkOutput("mrn_pre_q", {4'b0, q}, 8'b0100);
        mrn = 1'b0;
        #1;
        checkOutput("mrn_clear", {2'b0, done, s1, s0, dsl, dsr, 1'b0}, 8'd0);
        checkOutput("mrn_q_dout", {q, d_out}, 8'd0);
        @(negedge cp);
        mrn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            stepCycle();
            checkOutput("mrn_no_done", {7'b0, done}, 8'd0);
        end
        checkOutput("mrn_ready", {7'b0, cmd_ready}, 8'd1);
        applyStimulus(2'b00, 4'd0, 4'b0110, 1'b0);
        stepCycle();
        checkOutput("post_mrn_load", {3'b0, done, q}, 8'b10110);
        stepCycle();

`ifdef HC194_SEQ_ABORT_EN
        // ABORT seen on the second shift edge: 0110 -> 1100 -> 1000, then hold
        applyStimulus(2'b10, 4'd10, 4'b0000, 1'b0);
        stepCycle();
        checkOutput("abort_q1", {4'b0, q}, 8'b1100);
        abort = 1'b1;
        stepCycle();
        abort = 1'b0;
        checkOutput("abort_fin", {4'b0, done, aborted, s1, s0}, 8'b1100);
        checkOutput("abort_q2", {4'b0, q}, 8'b1000);
        stepCycle();
        checkOutput("abort_hold", {2'b0, cmd_ready, aborted, q}, 8'b101000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
